ibex_bcp_region_checker: RTL and testbench
==========================================

// Module: ibex_bcp_region_checker
// PURPOSE
// Bound-checking (BCP) unit for the EX stage: checks one load/store/arith address range against
// NumRegions base/limit regions, scanning RegionsPerCycle regions per cycle, and returns a registered
// hit/error response over valid/ready. It drives the bcp_*_addr_err signals to ID.
// PARAMETERS
// NumRegions       16  number of BCP regions; must be a multiple of RegionsPerCycle
// RegionsPerCycle   4  regions compared per SCAN cycle (>=1); scan chunks NC = NumRegions/RegionsPerCycle
// AddrWidth        32  address width
// PORTS
// clk_i              in   1               clock
// rst_i              in   1               synchronous reset, active-high
// flush_i            in   1               abort in-flight check, no response
// req_valid_i        in   1               request valid
// req_ready_o        out  1               request accepted when valid&ready
// req_addr_i         in   AddrWidth       access start address
// req_size_i         in   2               0 byte, 1 half, 2 word, 3 illegal
// req_type_i         in   2               0 load, 1 store, 2 arith, 3 illegal
// region_base_i      in   NumRegions*AW   region i base at [i*AW +: AW], inclusive
// region_limit_i     in   NumRegions*AW   region i limit, inclusive
// region_cfg_i       in   NumRegions*4    region i {en, ar, st, ld} at [i*4 +: 4]
// default_allow_i    in   1               mseccfg: allow access matching no region
// rsp_valid_o        out  1               response valid
// rsp_ready_i        in   1               response consumed
// rsp_hit_o          out  1               some region overlapped the access
// rsp_region_o       out  clog2(NumRegions) deciding region index (0 when no hit)
// rsp_load_err_o     out  1               load error; at most one err output set
// rsp_store_err_o    out  1               store error
// rsp_arith_err_o    out  1               arith error
// BEHAVIOUR
// - Reset: state IDLE, req_ready_o=1, rsp_valid_o=0, rsp_hit_o=0, rsp_region_o=0, all err=0.
// - FSM IDLE->SCAN on accept; SCAN->RESP on deciding match or after chunk NC-1; RESP->IDLE on rsp_ready_i.
// - req_ready_o = (state==IDLE); no same-cycle accept while leaving RESP.
// - Accept captures addr, type, and end = addr + (1<<size) - 1 computed on AW+1 bits.
// - Immediate error (IDLE->RESP, no scan): size==3, type==3, or end carry (wrap past 2^AW); type 3 sets no err bit, hit=0.
// - SCAN cycle k compares regions k*RPC..k*RPC+RPC-1; enabled region i overlaps iff addr<=limit && end>=base.
// - Lowest-index overlapping region decides; later regions and chunks are ignored and the scan stops early.
// - Full containment (base<=addr && end<=limit) with the type's permission bit set -> allowed.
// - Containment without permission, or partial overlap (straddle) -> error.
// - No overlap in any chunk: hit=0, region=0, err = ~default_allow_i.
// - Error maps one-hot by captured type: load->load_err, store->store_err, arith->arith_err.
// - Latency: accept at cycle T, deciding chunk c (0-based) -> rsp_valid_o from T+2+c; no-match -> T+1+NC.
// - Region inputs are sampled live each SCAN cycle; software must not change them mid-check.
// - RESP: all rsp_* outputs stable while rsp_valid_o && !rsp_ready_i.
// - flush_i in any state: next cycle IDLE, rsp_valid_o=0, outputs cleared. rst_i has priority over flush_i.
// - rst_i mid-operation: same as the reset values above; the pending check is discarded.
// - Out-of-range req_* or region inputs never cause X: illegal values are handled as listed above.
// TESTING
// NR=16,RPC=4. R0=[0x1000,0x1FFF] en,ld; load word @0x1004 at T -> rsp_valid T+2, hit=1, region=0, no err
// R13=[0x8000,0x80FF] en,st, others off; store half @0x8010 -> rsp_valid T+5, hit=1, region=13, no err
// R0 as above; load word @0x1FFE (straddle) -> T+2, hit=1, load_err=1; store @0x1004 -> store_err=1
// All regions off; arith byte @0x40 with default_allow=0 -> T+5, arith_err=1, hit=0; with default_allow=1 -> no err
// load word @0xFFFFFFFE -> rsp_valid T+1, load_err=1; size=3 -> rsp_valid T+1, err for type
// rsp_ready low 3 cycles -> outputs held; flush_i in SCAN -> no rsp, ready=1 next; rst_i mid-SCAN -> reset values

Source files
------------

// File: rtl/ibex_bcp_region_checker.sv
// Bound-checking unit: matches one access range against base/limit regions,
// scanning a few regions per cycle, and returns a registered hit/error response.
module ibex_bcp_region_checker #(
    parameter int unsigned NumRegions      = 16,
    parameter int unsigned RegionsPerCycle = 4,
    parameter int unsigned AddrWidth       = 32
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              flush_i,
    input  logic                              req_valid_i,
    output logic                              req_ready_o,
    input  logic [AddrWidth-1:0]              req_addr_i,
    input  logic [1:0]                        req_size_i,
    input  logic [1:0]                        req_type_i,
    input  logic [NumRegions*AddrWidth-1:0]   region_base_i,
    input  logic [NumRegions*AddrWidth-1:0]   region_limit_i,
    input  logic [NumRegions*4-1:0]           region_cfg_i,
    input  logic                              default_allow_i,
    output logic                              rsp_valid_o,
    input  logic                              rsp_ready_i,
    output logic                              rsp_hit_o,
    output logic [((NumRegions > 1) ? $clog2(NumRegions) : 1)-1:0] rsp_region_o,
    output logic                              rsp_load_err_o,
    output logic                              rsp_store_err_o,
    output logic                              rsp_arith_err_o
);

    localparam int unsigned NumChunks = NumRegions / RegionsPerCycle;
    localparam int unsigned CntW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
    localparam int unsigned RegW      = (NumRegions > 1) ? $clog2(NumRegions) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [AddrWidth-1:0] end_q, end_d;
    logic [1:0]           type_q, type_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 ready_q, ready_d;
    logic                 valid_q, valid_d;
    logic                 hit_q, hit_d;
    logic [RegW-1:0]      region_q, region_d;
    logic [2:0]           err_q, err_d;   // {arith, store, load}

    logic [AddrWidth:0]   req_end;
    logic                 found;
    logic                 found_ok;
    logic [RegW-1:0]      found_idx;
    int unsigned          idx;
    logic [AddrWidth-1:0] base;
    logic [AddrWidth-1:0] limit;
    logic [3:0]           cfg;

    // Inclusive end address with carry bit to detect wrap past the top.
    assign req_end = {1'b0, req_addr_i}
                   + ((AddrWidth+1)'(1) << req_size_i)
                   - (AddrWidth+1)'(1);

    // One-hot error by access type; type 3 never sets a bit.
    function automatic logic [2:0] err_vec(input logic [1:0] t, input logic e);
        logic [2:0] v;
        v = 3'b000;
        if (e) begin
            case (t)
                2'd0:    v = 3'b001;
                2'd1:    v = 3'b010;
                2'd2:    v = 3'b100;
                default: v = 3'b000;
            endcase
        end
        return v;
    endfunction

    // Lowest-index overlapping enabled region in the current chunk.
    always_comb begin
        found     = 1'b0;
        found_ok  = 1'b0;
        found_idx = '0;
        idx       = 0;
        base      = '0;
        limit     = '0;
        cfg       = '0;
        for (int unsigned j = 0; j < RegionsPerCycle; j++) begin
            idx   = 32'(cnt_q) * RegionsPerCycle + j;
            base  = region_base_i[idx*AddrWidth +: AddrWidth];
            limit = region_limit_i[idx*AddrWidth +: AddrWidth];
            cfg   = region_cfg_i[idx*4 +: 4];
            if (!found && cfg[3] && (addr_q <= limit) && (end_q >= base)) begin
                found     = 1'b1;
                found_idx = RegW'(idx);
                found_ok  = (base <= addr_q) && (end_q <= limit) && cfg[type_q];
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        end_d    = end_q;
        type_d   = type_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        hit_d    = hit_q;
        region_d = region_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    addr_d = req_addr_i;
                    end_d  = req_end[AddrWidth-1:0];
                    type_d = req_type_i;
                    cnt_d  = '0;
                    if ((req_size_i == 2'd3) || (req_type_i == 2'd3) || req_end[AddrWidth]) begin
                        state_d  = RESP;
                        valid_d  = 1'b1;
                        hit_d    = 1'b0;
                        region_d = '0;
                        err_d    = err_vec(req_type_i, 1'b1);
                    end else begin
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                if (found) begin
                    state_d  = RESP;
                    valid_d  = 1'b1;
                    hit_d    = 1'b1;
                    region_d = found_idx;
                    err_d    = err_vec(type_q, !found_ok);
                end else if (cnt_q == CntW'(NumChunks - 1)) begin
                    state_d  = RESP;
                    valid_d  = 1'b1;
                    hit_d    = 1'b0;
                    region_d = '0;
                    err_d    = err_vec(type_q, !default_allow_i);
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d  = IDLE;
                    valid_d  = 1'b0;
                    hit_d    = 1'b0;
                    region_d = '0;
                    err_d    = 3'b000;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush_i) begin
            state_d  = IDLE;
            valid_d  = 1'b0;
            hit_d    = 1'b0;
            region_d = '0;
            err_d    = 3'b000;
        end

        ready_d = (state_d == IDLE);
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            end_q    <= '0;
            type_q   <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            hit_q    <= 1'b0;
            region_q <= '0;
            err_q    <= 3'b000;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            end_q    <= end_d;
            type_q   <= type_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            hit_q    <= hit_d;
            region_q <= region_d;
            err_q    <= err_d;
        end
    end

    assign req_ready_o     = ready_q;
    assign rsp_valid_o     = valid_q;
    assign rsp_hit_o       = hit_q;
    assign rsp_region_o    = region_q;
    assign rsp_load_err_o  = err_q[0];
    assign rsp_store_err_o = err_q[1];
    assign rsp_arith_err_o = err_q[2];

endmodule

// File: tb/tb_ibex_bcp_region_checker.sv
// Directed bench for the bound-checking region checker (16 regions, 4 per cycle).
module tb_ibex_bcp_region_checker;

    localparam int unsigned NR = 16;
    localparam int unsigned AW = 32;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            flush_i;
    logic            req_valid_i;
    logic            req_ready_o;
    logic [AW-1:0]   req_addr_i;
    logic [1:0]      req_size_i;
    logic [1:0]      req_type_i;
    logic [NR*AW-1:0] region_base_i;
    logic [NR*AW-1:0] region_limit_i;
    logic [NR*4-1:0] region_cfg_i;
    logic            default_allow_i;
    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic            rsp_hit_o;
    logic [3:0]      rsp_region_o;
    logic            rsp_load_err_o;
    logic            rsp_store_err_o;
    logic            rsp_arith_err_o;

    int checks   = 0;
    int failures = 0;

    ibex_bcp_region_checker #(
        .NumRegions(NR), .RegionsPerCycle(4), .AddrWidth(AW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_size_i(req_size_i), .req_type_i(req_type_i),
        .region_base_i(region_base_i), .region_limit_i(region_limit_i),
        .region_cfg_i(region_cfg_i), .default_allow_i(default_allow_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_hit_o(rsp_hit_o), .rsp_region_o(rsp_region_o),
        .rsp_load_err_o(rsp_load_err_o), .rsp_store_err_o(rsp_store_err_o),
        .rsp_arith_err_o(rsp_arith_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_regions();
        region_base_i  = '0;
        region_limit_i = '0;
        region_cfg_i   = '0;
    endtask

    task automatic set_region(input int i, input logic [31:0] b, input logic [31:0] l,
                              input logic [3:0] c);
        region_base_i[i*AW +: AW]  = b;
        region_limit_i[i*AW +: AW] = l;
        region_cfg_i[i*4 +: 4]     = c;
    endtask

    // Present one request for a single cycle; returns cycles until rsp_valid.
    task automatic issue(input logic [31:0] addr, input logic [1:0] size,
                         input logic [1:0] typ, output int lat);
        req_addr_i  = addr;
        req_size_i  = size;
        req_type_i  = typ;
        req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        lat = 1;
        while (!rsp_valid_o && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic consume();
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
    endtask

    // Request, compare response against hand-computed values, then consume it.
    task automatic run(input string tag, input logic [31:0] addr, input logic [1:0] size,
                       input logic [1:0] typ, input int exp_lat, input logic exp_hit,
                       input logic [3:0] exp_region, input logic [2:0] exp_err);
        int lat;
        issue(addr, size, typ, lat);
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_hit"}, 32'(rsp_hit_o), 32'(exp_hit));
        check_eq({tag, "_region"}, 32'(rsp_region_o), 32'(exp_region));
        check_eq({tag, "_err"}, 32'({rsp_arith_err_o, rsp_store_err_o, rsp_load_err_o}),
                 32'(exp_err));
        consume();
        check_eq({tag, "_drop"}, 32'({rsp_valid_o, req_ready_o}), 32'(2'b01));
    endtask

    initial begin
        int lat;
        rst_i = 1'b1;
        flush_i = 1'b0;
        req_valid_i = 1'b0;
        req_addr_i = '0;
        req_size_i = '0;
        req_type_i = '0;
        rsp_ready_i = 1'b0;
        default_allow_i = 1'b0;
        clear_regions();
        tick();
        tick();
        rst_i = 1'b0;
        tick();

        check_eq("reset_ready", 32'(req_ready_o), 32'd1);
        check_eq("reset_outs", 32'({rsp_valid_o, rsp_hit_o, rsp_region_o,
                 rsp_arith_err_o, rsp_store_err_o, rsp_load_err_o}), 32'd0);

        // R0 load-only region; cfg bits {en, ar, st, ld}
        set_region(0, 32'h1000, 32'h1FFF, 4'b1001);
        run("load_ok",      32'h1004, 2'd2, 2'd0, 2, 1'b1, 4'd0, 3'b000);
        run("load_straddle", 32'h1FFE, 2'd2, 2'd0, 2, 1'b1, 4'd0, 3'b001);
        run("store_noperm", 32'h1004, 2'd2, 2'd1, 2, 1'b1, 4'd0, 3'b010);
        run("load_lastbyte", 32'h1FFF, 2'd0, 2'd0, 2, 1'b1, 4'd0, 3'b000);
        default_allow_i = 1'b1;
        run("past_limit",   32'h2000, 2'd0, 2'd0, 5, 1'b0, 4'd0, 3'b000);
        default_allow_i = 1'b0;

        // Only R13, store-permitted: decided in last chunk
        clear_regions();
        set_region(13, 32'h8000, 32'h80FF, 4'b1010);
        run("store_r13", 32'h8010, 2'd1, 2'd1, 5, 1'b1, 4'd13, 3'b000);

        // Lowest index decides: R1 store-only beats R2 load-allowed
        clear_regions();
        set_region(1, 32'h3000, 32'h3FFF, 4'b1010);
        set_region(2, 32'h3000, 32'h3FFF, 4'b1001);
        run("prio_low", 32'h3100, 2'd2, 2'd0, 2, 1'b1, 4'd1, 3'b001);

        // No regions enabled
        clear_regions();
        default_allow_i = 1'b0;
        run("nomatch_deny",  32'h40, 2'd0, 2'd2, 5, 1'b0, 4'd0, 3'b100);
        default_allow_i = 1'b1;
        run("nomatch_allow", 32'h40, 2'd0, 2'd2, 5, 1'b0, 4'd0, 3'b000);
        default_allow_i = 1'b0;

        // Immediate errors
        run("wrap",     32'hFFFF_FFFE, 2'd2, 2'd0, 1, 1'b0, 4'd0, 3'b001);
        run("size3",    32'h100, 2'd3, 2'd1, 1, 1'b0, 4'd0, 3'b010);
        run("type3",    32'h100, 2'd0, 2'd3, 1, 1'b0, 4'd0, 3'b000);

        // Response held while rsp_ready low
        set_region(0, 32'h1000, 32'h1FFF, 4'b1001);
        issue(32'h1FFE, 2'd2, 2'd0, lat);
        check_eq("hold_lat", 32'(lat), 32'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("hold_outs", 32'({rsp_valid_o, rsp_hit_o, rsp_region_o,
                     rsp_arith_err_o, rsp_store_err_o, rsp_load_err_o, req_ready_o}),
                     32'({1'b1, 1'b1, 4'd0, 3'b001, 1'b0}));
        end
        consume();
        check_eq("hold_drop", 32'({rsp_valid_o, req_ready_o}), 32'(2'b01));

        // Flush during scan
        clear_regions();
        req_addr_i = 32'h40; req_size_i = 2'd0; req_type_i = 2'd0;
        req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        check_eq("flush_inscan", 32'({rsp_valid_o, req_ready_o}), 32'(2'b00));
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check_eq("flush_next", 32'({rsp_valid_o, req_ready_o}), 32'(2'b01));
        for (int i = 0; i < 6; i++) tick();
        check_eq("flush_norsp", 32'(rsp_valid_o), 32'd0);

        // Reset during scan
        req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        tick();
        rst_i = 1'b1;
        flush_i = 1'b1;
        tick();
        rst_i = 1'b0;
        flush_i = 1'b0;
        check_eq("rst_scan", 32'({req_ready_o, rsp_valid_o, rsp_hit_o, rsp_region_o,
                 rsp_arith_err_o, rsp_store_err_o, rsp_load_err_o}), 32'h200);
        for (int i = 0; i < 6; i++) tick();
        check_eq("rst_norsp", 32'(rsp_valid_o), 32'd0);

        // Still functional after reset
        set_region(0, 32'h1000, 32'h1FFF, 4'b1001);
        run("post_rst", 32'h1004, 2'd2, 2'd0, 2, 1'b1, 4'd0, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
